// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU command sequencer and its datapath.
// Latency: n/a (declarations only).  Backpressure: n/a.
package alu_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 8;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              carry;
        logic              zero;
        logic              err;
    } res_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between a command source and the sequencer.
// Latency: n/a (wires only).  Backpressure: cmd_ready / res_ready.
interface alu_cmd_sequencer_if
    import alu_pkg::*;
#(
    parameter int ADDR_W = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ld;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_srca;
    logic [ADDR_W-1:0] cmd_srcb;
    logic [DATA_W-1:0] cmd_imm;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_carry;
    logic              res_zero;
    logic              res_err;

    modport master (
        output cmd_valid, cmd_ld, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero, res_err
    );

    modport slave (
        input  cmd_valid, cmd_ld, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero, res_err
    );
endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU: ADD/SUB/AND/OR/XOR/NOT a, zero result for illegal opcodes.
// Latency: 0 cycles.  Backpressure: none.
module alu_8bit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   alu_signal,
    output logic [DATA_W-1:0] alu_out,
    output logic              carry
);
    always_comb begin
        alu_out = '0;
        carry   = 1'b0;
        case (alu_signal)
            OP_ADD: {carry, alu_out} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                alu_out = a - b;
                carry   = (a < b);   // borrow
            end
            OP_AND: alu_out = a & b;
            OP_OR:  alu_out = a | b;
            OP_XOR: alu_out = a ^ b;
            OP_NOT: alu_out = ~a;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Register-file front-end for alu_8bit: IDLE accept -> EXEC compute/writeback -> RESP hold.
// Latency: 2 edges from accept to res_valid.  Backpressure: res_valid held until res_ready; cmd_ready only in IDLE.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int                REG_COUNT = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = 8'h00,
    localparam int               ADDR_W    = $clog2(REG_COUNT)
)(
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.slave   bus,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);
    state_t            state, state_nxt;
    logic [DATA_W-1:0] rf [REG_COUNT];
    logic [DATA_W-1:0] a_q, b_q, imm_q;
    logic [OP_W-1:0]   op_q;
    logic              ld_q;
    logic [ADDR_W-1:0] dst_q;
    res_t              res_q, exec_res;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              accept;

    alu_8bit u_alu (
        .a          (a_q),
        .b          (b_q),
        .alu_signal (op_q),
        .alu_out    (alu_out),
        .carry      (alu_carry)
    );

    // cmd_ready is gated by rst so it drops combinationally the moment reset asserts
    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.res_valid = (state == RESP);
    assign bus.res_data  = res_q.data;
    assign bus.res_carry = res_q.carry;
    assign bus.res_zero  = res_q.zero;
    assign bus.res_err   = res_q.err;
    assign dbg_data      = rf[dbg_addr];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        exec_res       = '0;
        exec_res.err   = !ld_q && !op_legal(op_q);
        exec_res.data  = ld_q ? imm_q : (exec_res.err ? '0 : alu_out);
        exec_res.carry = !ld_q && !exec_res.err && alu_carry;
        exec_res.zero  = (exec_res.data == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            op_q  <= OP_ADD;
            ld_q  <= 1'b0;
            dst_q <= '0;
        end else if (accept) begin
            a_q   <= rf[bus.cmd_srca];
            b_q   <= rf[bus.cmd_srcb];
            imm_q <= bus.cmd_imm;
            op_q  <= bus.cmd_op;
            ld_q  <= bus.cmd_ld;
            dst_q <= bus.cmd_dst;
        end
    end

    // Result and writeback share the EXEC edge, so the next accept already sees the new value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) rf[i] <= RESET_VAL;
        end else if (state == EXEC) begin
            res_q <= exec_res;
            if (!exec_res.err) rf[dst_q] <= exec_res.data;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed plus randomized bench for alu_cmd_sequencer against an arithmetic reference model.
// Latency: n/a.  Backpressure: exercises held res_ready=0 in RESP.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    int         compared   = 0;
    int         mismatched = 0;
    int         mrf [4];

    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.REG_COUNT(4), .RESET_VAL(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference result from the opcode rules, using plain integer arithmetic
    task automatic model(input bit ld, input int op, input int a, input int b, input int imm,
                         output int d, output bit c, output bit z, output bit e);
        int s;
        d = 0; c = 0; e = 0;
        if (ld) d = imm;
        else case (op)
            0: begin s = a + b; d = s % 256; c = (s > 255); end
            1: begin d = (a - b + 256) % 256; c = (a < b); end
            2: d = a & b;
            3: d = a | b;
            4: d = a ^ b;
            5: d = (~a) & 255;
            default: e = 1;
        endcase
        z = (d == 0);
    endtask

    task automatic check_reg(input string tag, input int idx, input int want);
        dbg_addr = idx[1:0];
        #1;
        check(tag, dbg_data, want);
    endtask

    task automatic do_cmd(input string tag, input bit ld, input int op, input int dst,
                          input int srca, input int srcb, input int imm);
        int d, cyc;
        bit c, z, e;
        model(ld, op, mrf[srca], mrf[srcb], imm, d, c, z, e);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_ld    = ld;
        bus.cmd_op    = op[2:0];
        bus.cmd_dst   = dst[1:0];
        bus.cmd_srca  = srca[1:0];
        bus.cmd_srcb  = srcb[1:0];
        bus.cmd_imm   = imm[7:0];
        bus.res_ready = 1'b1;
        cyc = 0;
        while (!bus.cmd_ready && cyc < 10) begin @(negedge clk); cyc++; end
        check({tag, ".cmd_ready"}, bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        cyc = 0;
        while (!bus.res_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
        check({tag, ".latency"}, cyc, 1);
        check({tag, ".data"},  bus.res_data,  d);
        check({tag, ".carry"}, bus.res_carry, 32'(c));
        check({tag, ".zero"},  bus.res_zero,  32'(z));
        check({tag, ".err"},   bus.res_err,   32'(e));
        if (!e) mrf[dst] = d;
        @(posedge clk); #1;
        check({tag, ".idle"}, {bus.cmd_ready, bus.res_valid}, 2'b10);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int d, rd;
        bit c, z, e;
        bus.cmd_valid = 0; bus.cmd_ld = 0; bus.cmd_op = 0; bus.cmd_dst = 0;
        bus.cmd_srca = 0; bus.cmd_srcb = 0; bus.cmd_imm = 0; bus.res_ready = 1;
        dbg_addr = 0;
        for (int i = 0; i < 4; i++) mrf[i] = 0;

        // Reset state
        #1;
        check("rst.cmd_ready", bus.cmd_ready, 0);
        check("rst.res_valid", bus.res_valid, 0);
        check("rst.res_flags", {bus.res_data, bus.res_carry, bus.res_zero, bus.res_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst.release_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 4; i++) check_reg("rst.reg", i, 0);

        // ADD without carry, then debug read
        do_cmd("ld_r0", 1, 0, 0, 0, 0, 8'h25);
        do_cmd("ld_r1", 1, 0, 1, 0, 0, 8'h13);
        do_cmd("add_r2", 0, 0, 2, 0, 1, 0);
        check_reg("add_r2.dbg", 2, 8'h38);

        // ADD wrap with carry, SUB with borrow into the same register it reads
        do_cmd("ld_r0b", 1, 0, 0, 0, 0, 8'hFF);
        do_cmd("ld_r1b", 1, 0, 1, 0, 0, 8'h01);
        do_cmd("add_r3", 0, 0, 3, 0, 1, 0);
        check_reg("add_r3.dbg", 3, 8'h00);
        do_cmd("sub_r0", 0, 1, 0, 1, 0, 0);
        check_reg("sub_r0.dbg", 0, 8'h02);

        // Logic ops on 25/13
        do_cmd("ld_r0c", 1, 0, 0, 0, 0, 8'h25);
        do_cmd("ld_r1c", 1, 0, 1, 0, 0, 8'h13);
        do_cmd("and", 0, 2, 2, 0, 1, 0);
        check_reg("and.dbg", 2, 8'h01);
        do_cmd("or",  0, 3, 3, 0, 1, 0);
        check_reg("or.dbg", 3, 8'h37);
        do_cmd("xor", 0, 4, 2, 0, 1, 0);
        check_reg("xor.dbg", 2, 8'h36);
        do_cmd("not", 0, 5, 3, 0, 1, 0);
        check_reg("not.dbg", 3, 8'hDA);

        // Illegal opcode leaves destination untouched
        do_cmd("illegal", 0, 7, 2, 0, 1, 0);
        check_reg("illegal.r2", 2, 8'h36);

        // Backpressure: hold RESP for 5 cycles while a competing command is offered
        model(0, 0, mrf[0], mrf[0], 0, d, c, z, e);
        @(negedge clk);
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_ld = 0; bus.cmd_op = 3'd0;
        bus.cmd_dst = 2'd1; bus.cmd_srca = 2'd0; bus.cmd_srcb = 2'd0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        mrf[1] = d;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_ld = 1; bus.cmd_dst = 2'd0; bus.cmd_imm = 8'hAA;
            @(posedge clk); #1;
            check("bp.hold", {bus.res_valid, bus.cmd_ready, bus.res_data, bus.res_carry,
                              bus.res_zero, bus.res_err}, {2'b10, d[7:0], c, z, e});
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.release", {bus.cmd_ready, bus.res_valid}, 2'b10);
        check_reg("bp.r0_unchanged", 0, mrf[0]);
        check_reg("bp.r1_written", 1, mrf[1]);

        // Randomized commands against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                do_cmd("rnd_ld", 1, $urandom_range(0, 7), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
            else
                do_cmd("rnd_op", 0, $urandom_range(0, 7), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
            rd = $urandom_range(0, 3);
            check_reg("rnd.dbg", rd, mrf[rd]);
        end

        // Reset in EXEC aborts the command and clears the register file
        do_cmd("ld_r3", 1, 0, 3, 0, 0, 8'h5A);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_ld = 1; bus.cmd_dst = 2'd2; bus.cmd_imm = 8'h77;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst.outputs", {bus.cmd_ready, bus.res_valid}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mrf[i] = 0;
        #1;
        check("arst.cmd_ready", bus.cmd_ready, 1);
        for (int i = 0; i < 4; i++) check_reg("arst.reg", i, 0);
        do_cmd("post_rst_add", 0, 0, 1, 2, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
